// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame constants and the
// odd-parity helper used when latching a command byte.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  localparam int PS2_DATA_BITS = 8;
  // Device falls that move host data: 8 data + parity + stop.
  localparam int PS2_TX_FALLS  = 10;

  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// 3-flop synchronizer with falling-edge detect for asynchronous PS/2 lines.
//   clk, resetn : system clock, synchronous active-low reset
//   din         : raw line inputs
//   sync        : synchronized line values
//   fall        : one-cycle pulse when the synchronized value goes 1->0
module ps2_sync_edge #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] fall
);

  // Stages 0/1 resolve metastability, stage 2 is the previous value.
  logic [2:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk) begin
    if (!resetn) pipe <= '1;   // idle PS/2 lines are high
    else         pipe <= {pipe[1:0], din};
  end

  assign sync = pipe[1];
  assign fall = pipe[2] & ~pipe[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, requests to send, shifts
// out one command byte with odd parity and stop, then samples the device ack.
//   clk, resetn          : system clock, synchronous active-low reset
//   tx_data/valid/ready  : byte-level handshake, accepted only in IDLE
//   ps2_clk, ps2_data    : asynchronous open-drain line inputs
//   ps2_clk_oe/data_oe   : 1 = pull the line low
//   done, ack_ok, err    : end-of-frame pulse with result
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       ack_ok,
  output logic       err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_tx_state_t            state;
  logic [PS2_DATA_BITS-1:0] data_q;
  logic                     parity_q;
  logic                     ack_q;
  logic [3:0]               n;
  logic [IW-1:0]            icnt;
  logic [TW-1:0]            tcnt;

  logic [1:0] line_sync, line_fall;
  logic       clk_s, data_s, clk_fall;
  logic       unused;
  logic       busy, timeout;

  ps2_sync_edge #(.WIDTH(2)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    ({ps2_data, ps2_clk}),
    .sync   (line_sync),
    .fall   (line_fall)
  );

  assign clk_s    = line_sync[0];
  assign data_s   = line_sync[1];
  assign clk_fall = line_fall[0];
  assign unused   = line_fall[1];

  assign busy    = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
  assign timeout = busy && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    done   <= 1'b0;
    ack_ok <= 1'b0;
    err    <= 1'b0;
    if (!resetn) begin
      state       <= IDLE;
      tx_ready    <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      data_q      <= '0;
      parity_q    <= 1'b0;
      ack_q       <= 1'b0;
      n           <= '0;
      icnt        <= '0;
      tcnt        <= '0;
    end else if (timeout) begin
      state       <= IDLE;
      tx_ready    <= 1'b1;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b1;
      err         <= 1'b1;
    end else begin
      // Free-running outside the frame; cleared on SEND entry.
      tcnt <= tcnt + 1'b1;
      case (state)
        IDLE: begin
          tx_ready <= 1'b1;
          if (tx_valid && tx_ready) begin
            data_q      <= tx_data;
            parity_q    <= odd_parity(tx_data);
            icnt        <= '0;
            ps2_clk_oe  <= 1'b1;
            // Start bit must already be low on the last inhibit cycle.
            ps2_data_oe <= (INHIBIT_CYCLES == 1);
            tx_ready    <= 1'b0;
            state       <= INHIBIT;
          end
        end
        INHIBIT: begin
          // Falls here are our own clock pull-down or device glitches.
          icnt <= icnt + 1'b1;
          if (INHIBIT_CYCLES >= 2 && icnt == IW'(INHIBIT_CYCLES - 2))
            ps2_data_oe <= 1'b1;
          if (icnt == IW'(INHIBIT_CYCLES - 1)) begin
            ps2_clk_oe <= 1'b0;
            n          <= '0;
            tcnt       <= '0;
            state      <= SEND;
          end
        end
        SEND: begin
          if (clk_fall) begin
            n <= n + 1'b1;
            if (n < 4'(PS2_DATA_BITS))
              ps2_data_oe <= ~data_q[n[2:0]];
            else if (n == 4'(PS2_DATA_BITS))
              ps2_data_oe <= ~parity_q;
            else if (n == 4'(PS2_TX_FALLS - 1)) begin
              ps2_data_oe <= 1'b0;   // stop bit: release data
              state       <= ACK;
            end
          end
        end
        ACK: begin
          if (clk_fall) begin
            ack_q <= ~data_s;
            state <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (clk_s && data_s) begin
            done     <= 1'b1;
            ack_ok   <= ack_q;
            err      <= ~ack_q;
            tx_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a scaled PS/2 device model on
// open-drain lines.
module tb_ps2_host_tx;

  localparam int HALF = 30;   // device clock half period in clk cycles

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk, ps2_data;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       done, ack_ok, err;
  logic       dev_clk_lo = 1'b0;
  logic       dev_data_lo = 1'b0;

  assign ps2_clk  = ~(ps2_clk_oe | dev_clk_lo);
  assign ps2_data = ~(ps2_data_oe | dev_data_lo);

  ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(4000)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .done        (done),
    .ack_ok      (ack_ok),
    .err         (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Monitor: cycle count, clk_oe activity and done events, sampled after edges.
  int   cyc = 0, oe_hi = 0, rise_cnt = 0, rise_cyc = 0, send_cyc = 0;
  int   done_cnt = 0, done_cyc = 0, rel_cyc = 0;
  logic done_ack = 1'b0, done_err = 1'b0, oe_q = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
    #2;
    if (ps2_clk_oe === 1'b1) oe_hi++;
    if (ps2_clk_oe === 1'b1 && oe_q !== 1'b1) begin rise_cnt++; rise_cyc = cyc; end
    if (ps2_clk_oe === 1'b0 && oe_q === 1'b1) send_cyc = cyc;
    oe_q = ps2_clk_oe;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      done_ack = ack_ok;
      done_err = err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_oe(input logic lvl, input int lim);
    int t = 0;
    while (ps2_clk_oe !== lvl && t < lim) begin @(negedge clk); t++; end
  endtask

  task automatic wait_done(input int base, input int lim);
    int t = 0;
    while (done_cnt == base && t < lim) begin @(negedge clk); t++; end
  endtask

  // Device: wait for inhibit and release, then clock nfalls bits out of the
  // host; bits[0] is the start bit. A full frame adds the ack clock.
  task automatic dev_frame(input int nfalls, input bit do_ack,
                           output logic [10:0] bits, output bit ok);
    int t;
    ok = 1'b1;
    bits = '0;
    t = 0;
    while (ps2_clk_oe !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) ok = 1'b0;
    t = 0;
    while (ps2_clk_oe !== 1'b0 && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) ok = 1'b0;
    repeat (HALF) @(negedge clk);
    bits[0] = ps2_data;
    for (int i = 1; i <= nfalls; i++) begin
      dev_clk_lo = 1'b1;
      repeat (HALF) @(negedge clk);
      bits[i] = ps2_data;
      dev_clk_lo = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    if (nfalls == 10) begin
      dev_data_lo = do_ack;
      repeat (4) @(negedge clk);
      dev_clk_lo = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_lo = 1'b0;
      repeat (4) @(negedge clk);
      dev_data_lo = 1'b0;
      rel_cyc = cyc;
    end
  endtask

  logic [10:0] b1, b2;
  bit          ok1, ok2;
  int          base, obase, rbase, acc_cyc;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", tx_ready, 0);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_done", done, 0);
    resetn = 1'b1;
    @(posedge clk); #2;
    chk("rel_ready", tx_ready, 1);
    @(negedge clk);

    // 0xED, device acks
    base = done_cnt; obase = oe_hi; acc_cyc = cyc;
    send(8'hED);
    chk("ed_oe_rise", rise_cyc, acc_cyc + 1);
    dev_frame(10, 1'b1, b1, ok1);
    wait_done(base, 100);
    chk("ed_dev_ok", ok1, 1);
    chk("ed_start", b1[0], 0);
    chk("ed_bits", b1[8:1], 8'hED);
    chk("ed_parity", b1[9], 1);
    chk("ed_stop", b1[10], 1);
    chk("ed_done", done_cnt, base + 1);
    chk("ed_ack", done_ack, 1);
    chk("ed_err", done_err, 0);
    chk("ed_inhibit", oe_hi - obase, 20);
    chk("ed_done_lat", done_cyc, rel_cyc + 3);
    chk("ed_ready", tx_ready, 1);

    // 0x3C, device nacks; tx_valid pulses while busy must be ignored
    repeat (5) @(negedge clk);
    base = done_cnt; rbase = rise_cnt;
    send(8'h3C);
    repeat (3) begin
      tx_data = 8'h55; tx_valid = 1'b1; @(negedge clk);
      tx_valid = 1'b0; @(negedge clk);
    end
    dev_frame(10, 1'b0, b1, ok1);
    wait_done(base, 100);
    chk("nak_bits", b1[8:1], 8'h3C);
    chk("nak_parity", b1[9], 1);
    chk("nak_done", done_cnt, base + 1);
    chk("nak_ack", done_ack, 0);
    chk("nak_err", done_err, 1);
    repeat (10) @(negedge clk);
    chk("nak_one_accept", rise_cnt - rbase, 1);

    // 0x01 then 0xFF back-to-back with tx_valid held
    base = done_cnt; rbase = rise_cnt;
    tx_data = 8'h01; tx_valid = 1'b1;
    wait_oe(1'b1, 10);
    tx_data = 8'hFF;
    dev_frame(10, 1'b1, b1, ok1);
    wait_oe(1'b1, 100);
    tx_valid = 1'b0;
    chk("b2b_done1", done_cnt, base + 1);
    chk("b2b_reaccept", rise_cyc, done_cyc + 1);
    dev_frame(10, 1'b1, b2, ok2);
    wait_done(base + 1, 100);
    chk("b2b_bits1", b1[8:1], 8'h01);
    chk("b2b_par1", b1[9], 0);
    chk("b2b_bits2", b2[8:1], 8'hFF);
    chk("b2b_par2", b2[9], 1);
    chk("b2b_done2", done_cnt, base + 2);
    chk("b2b_ack2", done_ack, 1);
    repeat (10) @(negedge clk);
    chk("b2b_accepts", rise_cnt - rbase, 2);

    // Clock glitch during inhibit
    base = done_cnt; obase = oe_hi;
    send(8'h5A);
    repeat (5) @(negedge clk);
    dev_clk_lo = 1'b1;
    @(negedge clk);
    dev_clk_lo = 1'b0;
    dev_frame(10, 1'b1, b1, ok1);
    wait_done(base, 100);
    chk("gl_start", b1[0], 0);
    chk("gl_bits", b1[8:1], 8'h5A);
    chk("gl_parity", b1[9], 1);
    chk("gl_stop", b1[10], 1);
    chk("gl_ack", done_ack, 1);
    chk("gl_inhibit", oe_hi - obase, 20);

    // Device never clocks: timeout
    repeat (5) @(negedge clk);
    base = done_cnt;
    send(8'hC3);
    dev_frame(0, 1'b0, b1, ok1);
    wait_done(base, 5000);
    chk("to_done", done_cnt, base + 1);
    chk("to_err", done_err, 1);
    chk("to_ack", done_ack, 0);
    chk("to_latency", done_cyc - send_cyc, 4000);
    chk("to_clk_oe", ps2_clk_oe, 0);
    chk("to_data_oe", ps2_data_oe, 0);
    chk("to_ready", tx_ready, 1);

    // Reset after fall 5 of 0x00
    repeat (5) @(negedge clk);
    base = done_cnt;
    send(8'h00);
    dev_frame(5, 1'b0, b1, ok1);
    chk("mr_data_oe_pre", ps2_data_oe, 1);
    resetn = 1'b0;
    @(posedge clk); #2;
    chk("mr_clk_oe", ps2_clk_oe, 0);
    chk("mr_data_oe", ps2_data_oe, 0);
    chk("mr_ready_lo", tx_ready, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #2;
    chk("mr_ready", tx_ready, 1);
    repeat (20) @(negedge clk);
    chk("mr_no_done", done_cnt, base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

- PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard on the same two open-drain lines that `ps2_keyboard` receives on.
- Sits beside `ps2_keyboard` in `top`.
- Performs the inhibit/request-to-send sequence, shifts out start, 8 data bits LSB-first, odd parity and stop, then checks the device acknowledge.
- Reports completion, and whether the byte was acknowledged, to a byte-level valid/ready client.

## Interface
- `INHIBIT_CYCLES`, default 5000: `clk` cycles the host holds `ps2_clk` low (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 1000000: maximum `clk` cycles from clock release to end of frame before abort.
- `clk`  in  1  system clock; the only clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `tx_data`  in  8  command byte; sampled on the accepting edge.
- `tx_valid`  in  1  request to send `tx_data`.
- `tx_ready`  out  1  high only in IDLE; a byte is accepted when `tx_valid && tx_ready`.
- `ps2_clk`  in  1  PS/2 clock line, asynchronous.
- `ps2_data`  in  1  PS/2 data line, asynchronous.
- `ps2_clk_oe`  out  1  1 = drive `ps2_clk` low; 0 = release.
- `ps2_data_oe`  out  1  1 = drive `ps2_data` low; 0 = release.
- `done`  out  1  one-cycle pulse at end of frame (ack, nack or timeout).
- `ack_ok`  out  1  valid with `done`: 1 = device acknowledged.
- `err`  out  1  valid with `done`: 1 = timeout or missing ack.

## Operation
- Line inputs pass through a 3-flop synchronizer. `fall` is high for one cycle when the synchronized clock goes 1→0.
- States and transitions:
  - IDLE: `tx_ready`=1. On accept, latch `tx_data` and parity = ~^`tx_data`, then go to INHIBIT.
  - INHIBIT: `ps2_clk_oe`=1 for exactly `INHIBIT_CYCLES` cycles. On the last cycle assert `ps2_data_oe`=1 (start bit), then go to SEND.
  - SEND: `ps2_clk_oe`=0 and `ps2_data_oe` is held. A 4-bit edge counter `n` starts at 0 and increments on each `fall`.
    - On fall n=1..8: `ps2_data_oe` = ~data[n-1].
    - On fall n=9: `ps2_data_oe` = ~parity.
    - On fall n=10: `ps2_data_oe`=0 (stop bit; line released).
    - After fall 10, go to ACK.
  - ACK: on the next `fall`, sample synchronized `ps2_data`. 0 means ack. Then go to WAIT_IDLE.
  - WAIT_IDLE: wait until both synchronized lines are 1. Then pulse `done` with `ack_ok`=ack and `err`=~ack, and return to IDLE.
- Timeout: a cycle counter runs from entry to SEND until exit from WAIT_IDLE. On reaching `TIMEOUT_CYCLES` from any of these states: release both lines, pulse `done` with `err`=1 and `ack_ok`=0, and go to IDLE.
- `tx_valid` is ignored whenever `tx_ready`=0; there is no queue.
- Data received by `ps2_keyboard` during a transmit is not this block's concern.

## Timing
- Reset (`resetn`=0 at a rising edge):
  - State becomes IDLE.
  - `ps2_clk_oe`=0, `ps2_data_oe`=0, `done`=0, `ack_ok`=0, `err`=0.
  - `tx_ready` is 0 while `resetn` is low and 1 on the first cycle after release.
- Reset mid-frame releases both lines on the next edge. No `done` is emitted.
- All outputs are registered.
- `ps2_clk_oe` rises on the cycle after the accept edge.
- `ps2_data_oe` updates 3 `clk` cycles after the physical falling edge (synchronizer plus register), far inside the device's ~30 µs low phase.
- `done` occurs 3 cycles after the later of the two lines rising. `tx_ready` returns on the same cycle as `done`.
- Back-to-back transfers: `tx_valid` held high is accepted again on the cycle after `done`.
- A `fall` during INHIBIT (device glitch) is ignored.
- The edge counter never wraps; the frame is fixed at 11 falls.

## Structure
- Package `ps2_pkg`:
  - state enum `ps2_tx_state_t` {IDLE, INHIBIT, SEND, ACK, WAIT_IDLE};
  - `PS2_DATA_BITS`=8;
  - `PS2_TX_FALLS`=10.
- Sub-module `ps2_sync_edge`: 3-flop synchronizer plus falling-edge detector, parameterized by width. The same module is reused by `ps2_keyboard`.

## Test plan
The bench uses a PS/2 device model clocking at 10-16.7 kHz (scaled), with `INHIBIT_CYCLES`=20 and `TIMEOUT_CYCLES`=4000.
- Send 0xED, device acks:
  - line bits after start are 1,0,1,1,0,1,1,1;
  - parity 1, stop 1;
  - `done` with `ack_ok`=1, `err`=0;
  - `ps2_clk_oe` high exactly 20 cycles.
- Send 0x01 then 0xFF with `tx_valid` held high:
  - parity 0 then 1;
  - second accept on the cycle after the first `done`;
  - `tx_valid` pulses while busy are ignored.
- Device leaves data high at fall 11 → `done` with `ack_ok`=0, `err`=1.
- Device never clocks after release → `done` with `err`=1 exactly 4000 cycles after SEND entry; both `oe` outputs are 0.
- Assert `resetn`=0 after fall 5 → both `oe` outputs are 0 on the next edge, no `done`, `tx_ready`=1 after release.
- Glitch: `ps2_clk` pulsed low for 1 `clk` cycle during INHIBIT → the bit sequence is still correct.
